// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared sizes and FSM state encoding for the 8-way arbiter
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - combinational 8->3 priority encoder, highest set index wins
module prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/prio_arbiter8.sv
// rtl/prio_arbiter8.sv - 8-requester arbiter: registered one-hot grant, hold,
// optional round-robin and a hold-time limit that forces release under contention
module prio_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rr_en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             preempt
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  state_t            state;
  logic [IDX_W-1:0]  last_owner;
  logic [N_REQ-1:0]  pmask;
  logic [HOLD_W-1:0] hold_cnt;

  logic [N_REQ-1:0]  eff;
  logic [N_REQ-1:0]  lo;
  logic [IDX_W-1:0]  idx_lo;
  logic [IDX_W-1:0]  idx_all;
  logic              any_lo;
  logic              any_all;
  logic [IDX_W-1:0]  win_idx;
  logic              hold_last;
  logic              contention;

  assign eff = req & ~pmask;
  // Round-robin looks first below the previous owner, then wraps to the top.
  assign lo  = eff & ((N_REQ'(1) << last_owner) - N_REQ'(1));

  prio_enc8 u_enc_lo (
    .vec (lo),
    .idx (idx_lo),
    .any (any_lo)
  );

  prio_enc8 u_enc_all (
    .vec (eff),
    .idx (idx_all),
    .any (any_all)
  );

  assign win_idx    = (rr_en && any_lo) ? idx_lo : idx_all;
  assign hold_last  = (hold_cnt == HOLD_LAST);
  assign contention = |(req & ~gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      gnt_idx    <= '0;
      gnt_vld    <= 1'b0;
      preempt    <= 1'b0;
      last_owner <= '0;
      hold_cnt   <= '0;
      pmask      <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        ST_IDLE: begin
          pmask <= '0;
          if (any_all) begin
            state    <= ST_BUSY;
            gnt      <= N_REQ'(1) << win_idx;
            gnt_idx  <= win_idx;
            gnt_vld  <= 1'b1;
            hold_cnt <= '0;
          end else begin
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (!req[gnt_idx]) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            gnt_idx    <= '0;
            gnt_vld    <= 1'b0;
            last_owner <= gnt_idx;
          end else if (HOLD_EN && hold_last && contention) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            gnt_idx    <= '0;
            gnt_vld    <= 1'b0;
            preempt    <= 1'b1;
            last_owner <= gnt_idx;
            pmask      <= gnt;
          end else if (!hold_last) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_arbiter8.sv
// tb/tb_prio_arbiter8.sv - scoreboard bench for prio_arbiter8 with a behavioural model
module tb_prio_arbiter8;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rr_en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  prio_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rr_en   (rr_en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       pre;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pre = 0;
  logic prev_vld = 1'b0;

  // Model: owner (-1 = nobody), cycles the grant has been visible, previous
  // owner, requester excluded from the next arbitration (-1 = none).
  int m_owner, m_held, m_last, m_excl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int top_bit(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 0; m_excl = -1;
  endtask

  task automatic model_step(input logic [7:0] r, input logic rr, output exp_t e);
    logic [7:0] eff;
    logic [7:0] lo;
    e.pre = 1'b0;
    if (m_owner < 0) begin
      eff = r;
      if (m_excl >= 0) eff[m_excl] = 1'b0;
      m_excl = -1;
      if (eff != 0) begin
        lo = '0;
        for (int i = 0; i < m_last; i++) lo[i] = eff[i];
        m_owner = (rr && lo != 0) ? top_bit(lo) : top_bit(eff);
        m_held  = 1;
      end
    end else if (!r[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && (r & ~(8'd1 << m_owner)) != 0) begin
      e.pre   = 1'b1;
      m_excl  = m_owner;
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_held++;
    end
    e.vld = (m_owner >= 0);
    e.idx = e.vld ? 3'(m_owner) : 3'd0;
    e.gnt = e.vld ? (8'd1 << m_owner) : 8'd0;
  endtask

  // Called at a falling edge: drive, predict the post-edge outputs, advance.
  task automatic drive(input logic [7:0] r, input logic rr);
    exp_t e;
    req   = r;
    rr_en = rr;
    model_step(r, rr, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check({name, "_len"}, grant_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
      check(name, grant_log[i], exp[i]);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("gnt", gnt, e.gnt);
          check("gnt_vld", gnt_vld, e.vld);
          check("preempt", preempt, e.pre);
          if (e.vld) check("gnt_idx", gnt_idx, e.idx);
        end
        check("onehot0", $onehot0(gnt), 1);
        check("vld_eq_or", gnt_vld, |gnt);
        if (gnt_vld) check("gnt_decode", gnt, 8'd1 << gnt_idx);
        if (gnt_vld && !prev_vld) grant_log.push_back(int'(gnt_idx));
        if (preempt) n_pre++;
        prev_vld = gnt_vld;
      end else begin
        prev_vld = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic       rr;
    rst_n = 1'b0;
    rr_en = 1'b0;
    req   = 8'h00;
    model_reset();
    #1;
    check("rst_gnt", gnt, 8'h00);
    check("rst_vld", gnt_vld, 1'b0);
    check("rst_idx", gnt_idx, 3'd0);
    check("rst_pre", preempt, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests
    n_pre = 0;
    repeat (5) drive(8'h00, 1'b0);
    check("t1_pre", n_pre, 0);
    check_log("t1_log", '{});

    // Fixed priority, 7 then 0
    grant_log.delete();
    repeat (3) drive(8'h81, 1'b0);
    drive(8'h01, 1'b0);
    repeat (3) drive(8'h01, 1'b0);
    check_log("t2_log", '{7, 0});
    repeat (2) drive(8'h00, 1'b0);

    // Round-robin rotation downward through all requesters
    grant_log.delete();
    drive(8'hFF, 1'b1);
    for (int k = 0; k < 9; k++) begin
      drive(8'hFF & ~(8'd1 << m_owner), 1'b1);
      drive(8'hFF, 1'b1);
    end
    check_log("t3_log", '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6});
    drive(8'h00, 1'b1);
    repeat (2) drive(8'h00, 1'b0);

    // Hold limit under contention
    grant_log.delete();
    n_pre = 0;
    repeat (11) drive(8'h30, 1'b0);
    check_log("t4_log", '{5, 4, 5});
    check("t4_pre", n_pre, 2);
    repeat (2) drive(8'h00, 1'b0);

    // Hold limit without contention never fires
    grant_log.delete();
    n_pre = 0;
    repeat (20) drive(8'h20, 1'b0);
    check_log("t5_log", '{5});
    check("t5_pre", n_pre, 0);

    // Asynchronous reset mid-grant
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_gnt", gnt, 8'h00);
    check("t6_vld", gnt_vld, 1'b0);
    check("t6_qempty", exp_q.size(), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete();
    repeat (3) drive(8'h0C, 1'b1);
    check_log("t6_log", '{3});
    repeat (2) drive(8'h00, 1'b0);

    // Random traffic
    r  = 8'h00;
    rr = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        r  = 8'($urandom);
        rr = 1'($urandom);
      end else if (m_owner >= 0 && $urandom_range(0, 5) == 0) begin
        r[m_owner] = 1'b0;
      end
      drive(r, rr);
    end

    check("final_qempty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
